// File: rtl/ntt_stage_sched_if.sv
// Signal bundle between the radix-8 NTT stage scheduler and its memory/butterfly datapath.
// master = scheduler side, slave = datapath/environment side.
interface ntt_stage_sched_if #(
   parameter int ADDR_W  = 9,
   parameter int STAGE_W = 2
);
   logic               start;
   logic               is_inv_ntt;
   logic               busy;
   logic               done;
   logic               rd_en;
   logic [ADDR_W-1:0]  rd_base;
   logic [ADDR_W-1:0]  rd_stride;
   logic               bf_valid_in;
   logic               bf_is_inv;
   logic               bf_valid_out;
   logic               wr_en;
   logic [ADDR_W-1:0]  wr_base;
   logic [ADDR_W-1:0]  wr_stride;
   logic [STAGE_W-1:0] wr_stage;
   logic               err;

   modport master (
      input  start, is_inv_ntt, bf_valid_out,
      output busy, done, rd_en, rd_base, rd_stride, bf_valid_in, bf_is_inv,
             wr_en, wr_base, wr_stride, wr_stage, err
   );

   modport slave (
      output start, is_inv_ntt, bf_valid_out,
      input  busy, done, rd_en, rd_base, rd_stride, bf_valid_in, bf_is_inv,
             wr_en, wr_base, wr_stride, wr_stage, err
   );
endinterface

// File: rtl/ntt_stage_sched.sv
// Radix-8 NTT stage scheduler: one 8-lane gather per cycle, in-flight group tags so
// butterfly results scatter back in place, and a drain barrier between stages.
module ntt_stage_sched #(
   parameter int STAGES     = 3,
   parameter int RD_LAT     = 1,
   parameter int BF_LAT     = 6,
   parameter int ADDR_W     = 3 * STAGES,
   parameter int FIFO_DEPTH = 1 << $clog2(RD_LAT + BF_LAT + 1)
) (
   input logic               clk,
   input logic               rst,
   ntt_stage_sched_if.master bus
);
   localparam int STAGE_W = (STAGES > 1) ? $clog2(STAGES) : 1;
   localparam int GRP_W   = ADDR_W - 3;
   localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(STAGES - 1);
   localparam logic [GRP_W-1:0]   GRP_LAST   = {GRP_W{1'b1}};
   localparam logic [ADDR_W-1:0]  STRIDE0    = ADDR_W'(1) << (3 * (STAGES - 1));

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]         state;
   logic [STAGE_W-1:0] stage;
   logic [GRP_W-1:0]   grp;
   logic [ADDR_W-1:0]  stride;
   logic               is_inv_q;
   logic               err_q;
   logic [RD_LAT-1:0]  vld_p1;

   logic               rd_en;
   logic               start_acc;
   logic               stage_adv;
   logic               push;
   logic               pop;
   logic               fifo_empty;
   logic [ADDR_W-1:0]  gather_base_p0;

   logic [ADDR_W-1:0]  tag_base   [FIFO_DEPTH];
   logic [ADDR_W-1:0]  tag_stride [FIFO_DEPTH];
   logic [STAGE_W-1:0] tag_stage  [FIFO_DEPTH];
   logic [PTR_W-1:0]   head;
   logic [PTR_W-1:0]   tail;
   logic [PTR_W:0]     cnt;

   // Stride is a power of two: (g/stride)*8*stride == (g & ~mask) << 3.
   function automatic logic [ADDR_W-1:0] group_base(input logic [GRP_W-1:0]  g,
                                                    input logic [ADDR_W-1:0] str);
      logic [ADDR_W-1:0] ge;
      logic [ADDR_W-1:0] mask;
      ge   = ADDR_W'(g);
      mask = str - ADDR_W'(1);
      return ((ge & ~mask) << 3) | (ge & mask);
   endfunction

   assign rd_en          = (state == S_RUN);
   assign start_acc      = (state == S_IDLE) && bus.start;
   assign fifo_empty     = (cnt == '0);
   assign stage_adv      = (state == S_DRAIN) && fifo_empty && (stage != STAGE_LAST);
   assign gather_base_p0 = group_base(grp, stride);
   assign push           = rd_en;
   assign pop            = bus.bf_valid_out && !fifo_empty;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         stage    <= '0;
         grp      <= '0;
         is_inv_q <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  state    <= S_RUN;
                  stage    <= '0;
                  grp      <= '0;
                  is_inv_q <= bus.is_inv_ntt;
               end
            end
            S_RUN: begin
               grp <= grp + GRP_W'(1);
               if (grp == GRP_LAST) state <= S_DRAIN;
            end
            S_DRAIN: begin
               if (fifo_empty) begin
                  if (stage == STAGE_LAST) begin
                     state <= S_DONE;
                  end else begin
                     stage <= stage + STAGE_W'(1);
                     grp   <= '0;
                     state <= S_RUN;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (start_acc)      stride <= STRIDE0;
      else if (stage_adv) stride <= stride >> 3;
   end

   // p0 -> p1: gather request travels the memory read latency to the butterfly.
   always_ff @(posedge clk) begin
      if (rst) vld_p1 <= '0;
      else     vld_p1 <= (vld_p1 << 1) | RD_LAT'(rd_en);
   end

   // Tag FIFO: one entry per gathered group, popped by each butterfly result.
   always_ff @(posedge clk) begin
      if (push) begin
         tag_base[tail]   <= gather_base_p0;
         tag_stride[tail] <= stride;
         tag_stage[tail]  <= stage;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head <= '0;
         tail <= '0;
         cnt  <= '0;
      end else begin
         if (push) tail <= tail + PTR_W'(1);
         if (pop)  head <= head + PTR_W'(1);
         case ({push, pop})
            2'b10:   cnt <= cnt + (PTR_W+1)'(1);
            2'b01:   cnt <= cnt - (PTR_W+1)'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst)                                   err_q <= 1'b0;
      else if (bus.bf_valid_out && fifo_empty)   err_q <= 1'b1;
   end

   assign bus.busy        = (state != S_IDLE);
   assign bus.done        = (state == S_DONE);
   assign bus.rd_en       = rd_en;
   assign bus.rd_base     = rd_en ? gather_base_p0 : '0;
   assign bus.rd_stride   = rd_en ? stride : '0;
   assign bus.bf_valid_in = vld_p1[RD_LAT-1];
   assign bus.bf_is_inv   = is_inv_q;
   assign bus.wr_en       = pop;
   assign bus.wr_base     = fifo_empty ? '0 : tag_base[head];
   assign bus.wr_stride   = fifo_empty ? '0 : tag_stride[head];
   assign bus.wr_stage    = fifo_empty ? '0 : tag_stage[head];
   assign bus.err         = err_q;
endmodule

// File: tb/tb_ntt_stage_sched.sv
// Directed bench for ntt_stage_sched: cycle-accurate control timing, gather/scatter
// addresses against a reference address model, direction latching, reset and error paths.
module tb_ntt_stage_sched;
   localparam int STAGES  = 3;
   localparam int RD_LAT  = 1;
   localparam int BF_LAT  = 6;
   localparam int ADDR_W  = 9;
   localparam int STAGE_W = 2;
   localparam int RUN_CYC = 226;
   localparam int N_GRP   = 192;

   logic              clk    = 1'b0;
   logic              rst    = 1'b1;
   logic              bf_inj = 1'b0;
   logic [BF_LAT-1:0] bf_sr;
   int                cyc    = 0;
   int                t0     = 0;
   bit                mon_on = 1'b0;
   int                n_vec  = 0;
   int                n_err  = 0;
   int                n_rd   = 0;
   int                n_wr   = 0;
   logic [4:0]        ctl_log [0:RUN_CYC-1];
   logic              inv_log [0:RUN_CYC-1];

   ntt_stage_sched_if #(.ADDR_W(ADDR_W), .STAGE_W(STAGE_W)) bus ();

   ntt_stage_sched #(
      .STAGES (STAGES),
      .RD_LAT (RD_LAT),
      .BF_LAT (BF_LAT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Butterfly stand-in: fixed 6-cycle valid delay, reset together with the scheduler.
   always @(posedge clk) begin
      if (rst) bf_sr <= '0;
      else     bf_sr <= {bf_sr[BF_LAT-2:0], bus.bf_valid_in};
   end
   assign bus.bf_valid_out = bf_sr[BF_LAT-1] | bf_inj;

   task automatic chk(input string tag, input int got, input int exp);
      n_vec++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int exp_stride(input int k);
      case (k / 64)
         0:       return 64;
         1:       return 8;
         default: return 1;
      endcase
   endfunction

   function automatic int exp_base(input int k);
      int g;
      int st;
      g  = k % 64;
      st = exp_stride(k);
      return (g / st) * 8 * st + (g % st);
   endfunction

   // {busy, done, rd_en, bf_valid_in, wr_en} relative to the start cycle.
   function automatic logic [4:0] exp_ctl(input int rc);
      logic b, d, r, v, w;
      b = (rc >= 1) && (rc <= 217);
      d = (rc == 217);
      r = (rc >= 1 && rc <= 64) || (rc >= 73 && rc <= 136) || (rc >= 145 && rc <= 208);
      v = (rc >= 2 && rc <= 65) || (rc >= 74 && rc <= 137) || (rc >= 146 && rc <= 209);
      w = (rc >= 8 && rc <= 71) || (rc >= 80 && rc <= 143) || (rc >= 152 && rc <= 215);
      return {b, d, r, v, w};
   endfunction

   always @(negedge clk) begin
      if (mon_on) begin
         if (cyc - t0 == 0) begin
            n_rd <= 0;
            n_wr <= 0;
         end
         if (cyc - t0 < RUN_CYC) begin
            ctl_log[cyc - t0] <= {bus.busy, bus.done, bus.rd_en, bus.bf_valid_in, bus.wr_en};
            inv_log[cyc - t0] <= bus.bf_is_inv;
         end
         if (bus.rd_en) begin
            if (n_rd < N_GRP) begin
               chk($sformatf("rd_base[%0d]", n_rd), int'(bus.rd_base), exp_base(n_rd));
               chk($sformatf("rd_stride[%0d]", n_rd), int'(bus.rd_stride), exp_stride(n_rd));
            end
            n_rd <= n_rd + 1;
         end
         if (bus.wr_en) begin
            if (n_wr < N_GRP) begin
               chk($sformatf("wr_base[%0d]", n_wr), int'(bus.wr_base), exp_base(n_wr));
               chk($sformatf("wr_stride[%0d]", n_wr), int'(bus.wr_stride), exp_stride(n_wr));
               chk($sformatf("wr_stage[%0d]", n_wr), int'(bus.wr_stage), n_wr / 64);
            end
            n_wr <= n_wr + 1;
         end
      end
   end

   task automatic do_run(input logic inv, input bit disturb);
      int n_inv;
      t0            = cyc;
      mon_on        = 1'b1;
      bus.start     = 1'b1;
      bus.is_inv_ntt = inv;
      for (int k = 1; k <= RUN_CYC; k++) begin
         step();
         bus.start = 1'b0;
         if (disturb && k == 40) bus.is_inv_ntt = ~inv;
         if (disturb && k == 50) bus.start = 1'b1;
      end
      mon_on = 1'b0;
      chk("rd_count", n_rd, N_GRP);
      chk("wr_count", n_wr, N_GRP);
      for (int rc = 0; rc < RUN_CYC; rc++)
         chk($sformatf("ctl@%0d", rc), int'(ctl_log[rc]), int'(exp_ctl(rc)));
      n_inv = 0;
      for (int rc = 1; rc < RUN_CYC; rc++)
         if (inv_log[rc] == inv) n_inv++;
      chk("bf_is_inv_held", n_inv, RUN_CYC - 1);
   endtask

   initial begin
      bus.start      = 1'b1;
      bus.is_inv_ntt = 1'b1;
      rst            = 1'b1;
      step();
      step();
      chk("rst_busy",        bus.busy,        0);
      chk("rst_done",        bus.done,        0);
      chk("rst_rd_en",       bus.rd_en,       0);
      chk("rst_bf_valid_in", bus.bf_valid_in, 0);
      chk("rst_wr_en",       bus.wr_en,       0);
      chk("rst_err",         bus.err,         0);
      chk("rst_rd_base",     bus.rd_base,     0);
      chk("rst_rd_stride",   bus.rd_stride,   0);
      chk("rst_wr_stage",    bus.wr_stage,    0);
      chk("rst_bf_is_inv",   bus.bf_is_inv,   0);
      rst            = 1'b0;
      bus.start      = 1'b0;
      bus.is_inv_ntt = 1'b0;
      step();
      chk("rst_start_ignored", bus.busy, 0);

      do_run(1'b0, 1'b0);
      chk("fwd_err", bus.err, 0);

      do_run(1'b1, 1'b1);

      // Reset in the middle of stage 0, then restart.
      bus.start = 1'b1;
      for (int k = 1; k <= 30; k++) begin
         step();
         bus.start = 1'b0;
      end
      chk("mid_pre_busy", bus.busy, 1);
      rst = 1'b1;
      step();
      rst    = 1'b0;
      bf_inj = 1'b1;
      #1;
      chk("mid_busy",        bus.busy,        0);
      chk("mid_rd_en",       bus.rd_en,       0);
      chk("mid_bf_valid_in", bus.bf_valid_in, 0);
      chk("mid_fifo_empty",  bus.wr_en,       0);
      step();
      bf_inj = 1'b0;
      chk("mid_err_set", bus.err, 1);
      step();
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      chk("restart_rd_en",     bus.rd_en,     1);
      chk("restart_rd_base",   bus.rd_base,   0);
      chk("restart_rd_stride", bus.rd_stride, 64);
      chk("restart_busy",      bus.busy,      1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("abort_busy",     bus.busy, 0);
      chk("rst_clears_err", bus.err,  0);

      // Stray butterfly output while idle.
      step();
      bf_inj = 1'b1;
      #1;
      chk("idle_pulse_wr_en", bus.wr_en, 0);
      step();
      bf_inj = 1'b0;
      chk("idle_pulse_err", bus.err, 1);
      step();
      do_run(1'b0, 1'b0);
      chk("err_sticky", bus.err, 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("err_cleared", bus.err, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
